y86_seq_ctrl: RTL and testbench
===============================

# y86_seq_ctrl

Multicycle sequencer for the Sequential Y86-64 datapath: steps each instruction through fetch, decode, execute, memory, write-back and PC-update, one stage enable at a time. Generates register-file write strobes, the condition-code write strobe and the data-memory request handshake. Tracks processor status and stops on halt or fault. Sits beside the fetch/decode/execute/memory/PC modules and drives their enables.

## Interface
- MEM_TO, 255: max cycles `dmem_req` may wait for `dmem_ready`; 0 disables the timeout
- CNT_W, 32: width of the performance counters
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- icode  in  4  instruction code from fetch; sampled in FETCH
- instr_valid  in  1  fetch decoded a legal instruction; sampled in FETCH
- imem_error  in  1  fetch address fault; sampled in FETCH
- dmem_ready  in  1  data memory completes the current request
- dmem_error  in  1  data memory address fault; qualified by `dmem_ready`
- f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  one-hot stage enables
- cc_we  out  1  condition-code write
- rf_we_e  out  1  register-file write of valE
- rf_we_m  out  1  register-file write of valM
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = write, 0 = read; valid while `dmem_req` is high
- stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS
- halted  out  1  controller is in HALT
- cycle_cnt  out  CNT_W  active cycles
- instr_cnt  out  CNT_W  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE:
  - `start`=1 -> FETCH.
  - `start` is ignored in every other state.
- FETCH:
  - `f_en`=1; `icode` is latched into `icode_q`.
  - Exit priority, highest first:
    - `imem_error` -> stat ADR, HALT
    - `!instr_valid` or `icode` > 4'hB -> stat INS, HALT
    - `icode`=4'h0 -> stat HLT, HALT
    - otherwise -> DECODE
- DECODE: `d_en`=1 -> EXECUTE.
- EXECUTE: `e_en`=1; `cc_we`=1 when `icode_q`=4'h6 -> MEMORY.
- MEMORY: `m_en`=1.
  - Memory icodes are 4, 5, 8, 9, A, B. For these, `dmem_req`=1 and `dmem_we`=1 for 4, 8, A.
  - Stay in MEMORY until `dmem_ready`=1.
  - `dmem_ready`=1 with `dmem_error`=1 -> stat ADR, HALT.
  - `dmem_ready`=1 without error -> WRITEBACK.
  - Timeout -> stat ADR, HALT.
  - Non-memory icodes: one cycle with no request -> WRITEBACK.
- WRITEBACK: `w_en`=1.
  - `rf_we_e`=1 for icodes 2, 3, 6, 8, 9, A, B.
  - `rf_we_m`=1 for icodes 5, B.
  - -> PCUPD.
- PCUPD: `pc_en`=1 -> FETCH.
- HALT: all strobes are 0, `halted`=1, `stat` holds. HALT is left only through `rst`.
- Strobes are Moore outputs decoded from state and `icode_q`.

## Timing
- Reset, asynchronous, valid at any point including mid-memory-wait:
  - state IDLE, `stat`=0
  - every strobe, `dmem_req`, `dmem_we` and `halted` = 0
  - counters = 0
- Non-memory instruction: 6 cycles, FETCH through PCUPD.
- Memory instruction: 6 + W cycles, where W is the number of cycles `dmem_req` is high before the cycle in which `dmem_ready`=1. `dmem_ready` in the first MEMORY cycle gives W=0.
- Memory handshake:
  - `dmem_req` and `dmem_we` stay stable until the `dmem_ready` cycle.
  - `dmem_req`=0 on the following cycle.
  - `dmem_ready` outside a request is ignored.
- Timeout: with MEM_TO=N>0, if `dmem_ready` has not arrived after N request cycles, HALT is entered on the next edge with stat ADR.
- A fault or halt detected in FETCH reaches HALT on the next edge. No D/E/M/W/PC strobe is issued for that instruction.

## Configuration
- `Y86_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle the state is neither IDLE nor HALT.
  - `instr_cnt` increments on each PCUPD cycle.
  - Both saturate at all-ones.
- Not defined: both ports are present and tied to 0, and no counter flops exist.

## Test plan
- Reset, `start`, then `icode` 6 with no faults -> `cc_we` and `rf_we_e` one cycle each; `pc_en` in cycle 6; FETCH again in cycle 7.
- `icode` 5, `dmem_ready` after 3 request cycles -> `dmem_req`=1 for 4 cycles with `dmem_we`=0; `rf_we_m`=1; 9 cycles total.
- `icode` A, `dmem_ready`=1 with `dmem_error`=1 -> `dmem_we`=1; next cycle `stat`=2, `halted`=1, no `w_en`.
- FETCH with `icode`=0 -> `stat`=1, HALT. Pulsing `start` afterwards leaves the controller in HALT.
- MEM_TO=4, `icode` 8 with `dmem_ready` held 0 -> HALT after 4 request cycles, `stat`=2.
- `rst` asserted during a MEMORY wait -> `dmem_req`=0 and state IDLE immediately. With `Y86_PERF_CNT_EN`, counters read 0.

Source files
------------

// File: rtl/y86_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// y86_seq_ctrl_if
// Bundles the sequencer's control, stage-enable, memory-handshake and status
// signals.
//   master : the sequencer. It samples start/icode/fetch status/dmem response
//            and drives enables, strobes, dmem request, stat and counters.
//   slave  : the datapath or bench side, with the opposite directions.
// Parameter CNT_W sets the width of the performance counter signals.
// ----------------------------------------------------------------------------
interface y86_seq_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // Inputs to the sequencer
    logic             start;
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_error;
    logic             dmem_ready;
    logic             dmem_error;
    // Stage enables
    logic             f_en;
    logic             d_en;
    logic             e_en;
    logic             m_en;
    logic             w_en;
    logic             pc_en;
    // Write strobes and memory request
    logic             cc_we;
    logic             rf_we_e;
    logic             rf_we_m;
    logic             dmem_req;
    logic             dmem_we;
    // Status and counters
    logic [1:0]       stat;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  start, icode, instr_valid, imem_error, dmem_ready, dmem_error,
        output f_en, d_en, e_en, m_en, w_en, pc_en,
        output cc_we, rf_we_e, rf_we_m, dmem_req, dmem_we,
        output stat, halted, cycle_cnt, instr_cnt
    );

    modport slave (
        output start, icode, instr_valid, imem_error, dmem_ready, dmem_error,
        input  f_en, d_en, e_en, m_en, w_en, pc_en,
        input  cc_we, rf_we_e, rf_we_m, dmem_req, dmem_we,
        input  stat, halted, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/y86_seq_ctrl.sv
// ----------------------------------------------------------------------------
// y86_seq_ctrl
// Multicycle sequencer for the sequential Y86-64 datapath. It walks each
// instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD with
// one stage enable active at a time. It also issues the CC and register-file
// write strobes and the data-memory request handshake. It stops in HALT on a
// halt instruction or on any fault.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : y86_seq_ctrl_if.master
//     in : start, icode, instr_valid, imem_error, dmem_ready, dmem_error
//     out: f_en, d_en, e_en, m_en, w_en, pc_en, cc_we, rf_we_e, rf_we_m,
//          dmem_req, dmem_we, stat, halted, cycle_cnt, instr_cnt
// Parameters:
//   MEM_TO : maximum dmem_req cycles without dmem_ready (0 = no timeout)
//   CNT_W  : performance counter width
// Build option:
//   Y86_PERF_CNT_EN : enables the saturating cycle and instruction counters.
//                     Without it, both counter ports are tied to 0.
// ----------------------------------------------------------------------------
module y86_seq_ctrl #(
    parameter int unsigned MEM_TO = 255,
    parameter int unsigned CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    y86_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StPcUpd,
        StHalt
    } state_e;

    localparam logic [1:0] StatAok = 2'd0;
    localparam logic [1:0] StatHlt = 2'd1;
    localparam logic [1:0] StatAdr = 2'd2;
    localparam logic [1:0] StatIns = 2'd3;

    // Wait counter holds the number of request cycles already spent. It only
    // needs to reach MEM_TO-1.
    localparam int unsigned WaitW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

    function automatic logic is_mem_op(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    function automatic logic is_mem_wr(input logic [3:0] ic);
        return ic inside {4'h4, 4'h8, 4'hA};
    endfunction

    function automatic logic writes_vale(input logic [3:0] ic);
        return ic inside {4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    function automatic logic writes_valm(input logic [3:0] ic);
        return ic inside {4'h5, 4'hB};
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         icode_q, icode_d;
    logic [1:0]         stat_q, stat_d;
    logic [WaitW-1:0]   wait_q, wait_d;

    logic f_en_q,     f_en_d;
    logic d_en_q,     d_en_d;
    logic e_en_q,     e_en_d;
    logic m_en_q,     m_en_d;
    logic w_en_q,     w_en_d;
    logic pc_en_q,    pc_en_d;
    logic cc_we_q,    cc_we_d;
    logic rf_we_e_q,  rf_we_e_d;
    logic rf_we_m_q,  rf_we_m_d;
    logic dmem_req_q, dmem_req_d;
    logic dmem_we_q,  dmem_we_d;
    logic halted_q,   halted_d;

    // Next state, latched icode, status and memory wait counter
    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        stat_d  = stat_q;
        wait_d  = wait_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                icode_d = bus.icode;
                if (bus.imem_error) begin
                    stat_d  = StatAdr;
                    state_d = StHalt;
                end else if (!bus.instr_valid || (bus.icode > 4'hB)) begin
                    stat_d  = StatIns;
                    state_d = StHalt;
                end else if (bus.icode == 4'h0) begin
                    stat_d  = StatHlt;
                    state_d = StHalt;
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                wait_d  = '0;
                state_d = StMemory;
            end
            StMemory: begin
                if (is_mem_op(icode_q)) begin
                    if (bus.dmem_ready) begin
                        if (bus.dmem_error) begin
                            stat_d  = StatAdr;
                            state_d = StHalt;
                        end else begin
                            state_d = StWriteback;
                        end
                    end else if ((MEM_TO != 0) && (wait_q == WaitW'(MEM_TO - 1))) begin
                        // This was the last allowed request cycle.
                        stat_d  = StatAdr;
                        state_d = StHalt;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end else begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                state_d = StPcUpd;
            end
            StPcUpd: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered Moore outputs. Decoding from the next state keeps each strobe
    // aligned with the state it belongs to.
    always_comb begin
        f_en_d     = (state_d == StFetch);
        d_en_d     = (state_d == StDecode);
        e_en_d     = (state_d == StExecute);
        m_en_d     = (state_d == StMemory);
        w_en_d     = (state_d == StWriteback);
        pc_en_d    = (state_d == StPcUpd);
        cc_we_d    = (state_d == StExecute) && (icode_d == 4'h6);
        rf_we_e_d  = (state_d == StWriteback) && writes_vale(icode_d);
        rf_we_m_d  = (state_d == StWriteback) && writes_valm(icode_d);
        dmem_req_d = (state_d == StMemory) && is_mem_op(icode_d);
        dmem_we_d  = (state_d == StMemory) && is_mem_op(icode_d) && is_mem_wr(icode_d);
        halted_d   = (state_d == StHalt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            icode_q    <= 4'h0;
            stat_q     <= StatAok;
            wait_q     <= '0;
            f_en_q     <= 1'b0;
            d_en_q     <= 1'b0;
            e_en_q     <= 1'b0;
            m_en_q     <= 1'b0;
            w_en_q     <= 1'b0;
            pc_en_q    <= 1'b0;
            cc_we_q    <= 1'b0;
            rf_we_e_q  <= 1'b0;
            rf_we_m_q  <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            icode_q    <= icode_d;
            stat_q     <= stat_d;
            wait_q     <= wait_d;
            f_en_q     <= f_en_d;
            d_en_q     <= d_en_d;
            e_en_q     <= e_en_d;
            m_en_q     <= m_en_d;
            w_en_q     <= w_en_d;
            pc_en_q    <= pc_en_d;
            cc_we_q    <= cc_we_d;
            rf_we_e_q  <= rf_we_e_d;
            rf_we_m_q  <= rf_we_m_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.f_en     = f_en_q;
    assign bus.d_en     = d_en_q;
    assign bus.e_en     = e_en_q;
    assign bus.m_en     = m_en_q;
    assign bus.w_en     = w_en_q;
    assign bus.pc_en    = pc_en_q;
    assign bus.cc_we    = cc_we_q;
    assign bus.rf_we_e  = rf_we_e_q;
    assign bus.rf_we_m  = rf_we_m_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.dmem_we  = dmem_we_q;
    assign bus.stat     = stat_q;
    assign bus.halted   = halted_q;

`ifdef Y86_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Saturating counters, driven from the current state
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if ((state_q != StIdle) && (state_q != StHalt) && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if ((state_q == StPcUpd) && (instr_cnt_q != '1)) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
`else
    assign bus.cycle_cnt = '0;
    assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_y86_seq_ctrl
// Directed, table-driven bench for y86_seq_ctrl with MEM_TO=4. Each table row
// resets the DUT, starts one instruction and tallies the strobes cycle by
// cycle until the controller refetches or halts. The tallies are then compared
// with hand-computed expectations. Hand-written sequences cover reset,
// start-in-HALT and reset during a memory wait.
// ----------------------------------------------------------------------------
module tb_y86_seq_ctrl;

    localparam int unsigned MemTo   = 4;
    localparam int unsigned CntW    = 32;
    localparam int          NoReady = 99;

    logic clk = 1'b0;
    logic rst;

    y86_seq_ctrl_if #(.CNT_W(CntW)) bus ();

    y86_seq_ctrl #(
        .MEM_TO (MemTo),
        .CNT_W  (CntW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] icode;
        logic       valid;
        logic       imem_err;
        int         w;          // request cycles before dmem_ready
        logic       derr;
        logic       rdy_idle;   // drive ready/error high outside requests
        int         e_act;      // active (enabled) cycles
        int         e_cc;
        int         e_rfe;
        int         e_rfm;
        int         e_req;
        int         e_we;
        int         e_wen;
        int         e_stat;
        int         e_halt;
        int         e_refetch;
    } vec_t;

    localparam int NVec = 17;
    vec_t vecs[NVec];

    int total;
    int bad;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start       = 1'b0;
        bus.icode       = 4'h0;
        bus.instr_valid = 1'b0;
        bus.imem_error  = 1'b0;
        bus.dmem_ready  = 1'b0;
        bus.dmem_error  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int all_strobes();
        return int'({bus.f_en, bus.d_en, bus.e_en, bus.m_en, bus.w_en, bus.pc_en,
                     bus.cc_we, bus.rf_we_e, bus.rf_we_m, bus.dmem_req, bus.dmem_we});
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int  act, cc, rfe, rfm, req, we, wen, viol, refetch, halt_seen;
        int  exp_cyc, exp_ins;
        bit  saw_pc, done;
        act = 0; cc = 0; rfe = 0; rfm = 0; req = 0; we = 0; wen = 0;
        viol = 0; refetch = 0; halt_seen = 0; saw_pc = 0; done = 0;

        apply_reset();
        @(negedge clk);
        bus.start       = 1'b1;
        bus.icode       = v.icode;
        bus.instr_valid = v.valid;
        bus.imem_error  = v.imem_err;
        bus.dmem_ready  = v.rdy_idle;
        bus.dmem_error  = v.rdy_idle;

        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.halted) begin
                halt_seen = 1;
                done      = 1;
                if (all_strobes() != 0) viol++;
            end else if (saw_pc && bus.f_en) begin
                refetch = 1;
                done    = 1;
            end else begin
                if ($countones({bus.f_en, bus.d_en, bus.e_en, bus.m_en, bus.w_en,
                                bus.pc_en}) != 1) viol++;
                if (bus.stat != 2'd0) viol++;
                if (bus.dmem_req && !bus.m_en) viol++;
                act++;
                cc  += int'(bus.cc_we);
                rfe += int'(bus.rf_we_e);
                rfm += int'(bus.rf_we_m);
                wen += int'(bus.w_en);
                if (bus.pc_en) saw_pc = 1;
                if (bus.dmem_req) begin
                    req++;
                    if (bus.dmem_we) we++;
                end
            end
            // Response for the coming edge
            if (bus.dmem_req) begin
                bus.dmem_ready = (v.w != NoReady) && (req == v.w + 1);
                bus.dmem_error = bus.dmem_ready && v.derr;
            end else begin
                bus.dmem_ready = v.rdy_idle;
                bus.dmem_error = v.rdy_idle;
            end
        end

        chk($sformatf("v%0d finished", idx), int'(done), 1);
        chk($sformatf("v%0d active_cycles", idx), act, v.e_act);
        chk($sformatf("v%0d cc_we", idx), cc, v.e_cc);
        chk($sformatf("v%0d rf_we_e", idx), rfe, v.e_rfe);
        chk($sformatf("v%0d rf_we_m", idx), rfm, v.e_rfm);
        chk($sformatf("v%0d dmem_req_cycles", idx), req, v.e_req);
        chk($sformatf("v%0d dmem_we_cycles", idx), we, v.e_we);
        chk($sformatf("v%0d w_en", idx), wen, v.e_wen);
        chk($sformatf("v%0d stat", idx), int'(bus.stat), v.e_stat);
        chk($sformatf("v%0d halted", idx), halt_seen, v.e_halt);
        chk($sformatf("v%0d refetch", idx), refetch, v.e_refetch);
        chk($sformatf("v%0d protocol_violations", idx), viol, 0);
`ifdef Y86_PERF_CNT_EN
        exp_cyc = v.e_act;
        exp_ins = v.e_refetch;
`else
        exp_cyc = 0;
        exp_ins = 0;
`endif
        chk($sformatf("v%0d cycle_cnt", idx), int'(bus.cycle_cnt), exp_cyc);
        chk($sformatf("v%0d instr_cnt", idx), int'(bus.instr_cnt), exp_ins);
    endtask

    initial begin
        int req_seen;
        total = 0;
        bad   = 0;

        //          icode valid imerr w        derr ridle | act cc rfe rfm req we wen stat halt refetch
        vecs[0]  = '{4'h6, 1'b1, 1'b0, 0,       1'b0, 1'b1,  6, 1, 1, 0, 0, 0, 1, 0, 0, 1};
        vecs[1]  = '{4'h5, 1'b1, 1'b0, 3,       1'b0, 1'b0,  9, 0, 0, 1, 4, 0, 1, 0, 0, 1};
        vecs[2]  = '{4'hA, 1'b1, 1'b0, 0,       1'b1, 1'b0,  4, 0, 0, 0, 1, 1, 0, 2, 1, 0};
        vecs[3]  = '{4'h8, 1'b1, 1'b0, NoReady, 1'b0, 1'b0,  7, 0, 0, 0, 4, 4, 0, 2, 1, 0};
        vecs[4]  = '{4'h0, 1'b1, 1'b0, 0,       1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        vecs[5]  = '{4'hC, 1'b1, 1'b0, 0,       1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0, 3, 1, 0};
        vecs[6]  = '{4'h2, 1'b0, 1'b0, 0,       1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0, 3, 1, 0};
        vecs[7]  = '{4'h0, 1'b0, 1'b1, 0,       1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0, 2, 1, 0};
        vecs[8]  = '{4'h0, 1'b0, 1'b0, 0,       1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0, 3, 1, 0};
        vecs[9]  = '{4'h4, 1'b1, 1'b0, 0,       1'b0, 1'b0,  6, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        vecs[10] = '{4'hB, 1'b1, 1'b0, 1,       1'b0, 1'b0,  7, 0, 1, 1, 2, 0, 1, 0, 0, 1};
        vecs[11] = '{4'h9, 1'b1, 1'b0, 2,       1'b0, 1'b0,  8, 0, 1, 0, 3, 0, 1, 0, 0, 1};
        vecs[12] = '{4'h3, 1'b1, 1'b0, 0,       1'b0, 1'b1,  6, 0, 1, 0, 0, 0, 1, 0, 0, 1};
        vecs[13] = '{4'h7, 1'b1, 1'b0, 0,       1'b0, 1'b0,  6, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        vecs[14] = '{4'h8, 1'b1, 1'b0, 0,       1'b0, 1'b0,  6, 0, 1, 0, 1, 1, 1, 0, 0, 1};
        vecs[15] = '{4'hF, 1'b1, 1'b0, 0,       1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0, 3, 1, 0};
        vecs[16] = '{4'h1, 1'b1, 1'b0, 0,       1'b0, 1'b1,  6, 0, 0, 0, 0, 0, 1, 0, 0, 1};

        // Reset state
        clear_inputs();
        rst = 1'b1;
        #13;
        chk("reset strobes", all_strobes(), 0);
        chk("reset stat", int'(bus.stat), 0);
        chk("reset halted", int'(bus.halted), 0);
        chk("reset cycle_cnt", int'(bus.cycle_cnt), 0);
        chk("reset instr_cnt", int'(bus.instr_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        // No start: the controller must stay idle
        repeat (3) @(negedge clk);
        chk("idle without start", all_strobes(), 0);

        for (int i = 0; i < NVec; i++) begin
            run_vec(i, vecs[i]);
        end

        // Halt on icode 0, then start pulses must not leave HALT
        run_vec(100, vecs[4]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt ignores start halted", int'(bus.halted), 1);
        chk("halt ignores start stat", int'(bus.stat), 1);
        chk("halt ignores start strobes", all_strobes(), 0);

        // Reset during a memory wait
        apply_reset();
        @(negedge clk);
        bus.start       = 1'b1;
        bus.icode       = 4'h5;
        bus.instr_valid = 1'b1;
        req_seen        = 0;
        for (int c = 0; c < 20 && req_seen < 2; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.dmem_req) req_seen++;
        end
        chk("midwait reached", req_seen, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midwait rst dmem_req", int'(bus.dmem_req), 0);
        chk("midwait rst strobes", all_strobes(), 0);
        chk("midwait rst stat", int'(bus.stat), 0);
        chk("midwait rst halted", int'(bus.halted), 0);
        chk("midwait rst cycle_cnt", int'(bus.cycle_cnt), 0);
        chk("midwait rst instr_cnt", int'(bus.instr_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("after rst stays idle", all_strobes(), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("after rst start fetches", int'(bus.f_en), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
